main_ctrl_fsm: RTL and testbench
================================

Name: main_ctrl_fsm

Overview:
Multi-cycle main control unit for the RV32 subset core. It fetches and holds the instruction word and decodes its opcode. It sequences FETCH/DECODE/EXEC/MEM/WB and generates the ALUOp, funct3 and funct7 that the ALU control decoder consumes. It also drives the datapath enables and handshakes with instruction and data memory.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid; instr sampled this cycle
instr  in  32  instruction word from instruction memory
dmem_req  out  1  data memory request
dmem_we  out  1  data write enable (sw), qualified by dmem_req
dmem_ready  in  1  data access complete
zero  in  1  ALU zero flag
ir_write  out  1  IR load strobe (datapath copy of instruction)
alu_op  out  2  ALUOp to ALU control: 00 add (ld/st), 01 sub (branch), 10 R-type, 11 pass U-imm
funct3  out  3  IR[14:12]
funct7  out  7  IR[31:25]
alu_src_b  out  1  0 = rs2, 1 = immediate
pc_write  out  1  PC update strobe
pc_src  out  1  0 = PC+4, 1 = branch target
reg_write  out  1  register file write strobe
mem_to_reg  out  1  writeback select: 1 = load data, 0 = ALU result
illegal  out  1  one-cycle pulse on an unsupported opcode
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, immediate):
  - state = FETCH, IR = 0, retired = 0.
  - All strobes 0, alu_op = 00.
  - Reset asserted mid-access abandons that access; no pc_write or reg_write is issued.
- Supported opcodes:
  - R-type 0110011
  - lw 0000011
  - sw 0100011
  - beq 1100011
  - lui 0110111
  - Any other opcode is illegal.
- FETCH:
  - imem_req = 1.
  - On imem_ready: IR <= instr, ir_write = 1 (same cycle, combinational on ready), next DECODE.
  - Otherwise stay in FETCH with imem_req held.
- DECODE (exactly 1 cycle):
  - Classify IR[6:0].
  - Illegal: illegal = 1, pc_write = 1, pc_src = 0, retired unchanged, next FETCH.
  - Legal: next EXEC.
- EXEC (1 cycle):
  - R-type: alu_op = 10, alu_src_b = 0, next WB.
  - lw/sw: alu_op = 00, alu_src_b = 1, next MEM.
  - beq: alu_op = 01, alu_src_b = 0, pc_write = 1, pc_src = zero, retired++, next FETCH.
  - lui: alu_op = 11, alu_src_b = 1, next WB.
- MEM:
  - alu_op = 00 and alu_src_b = 1 held so the address stays stable.
  - dmem_req = 1; dmem_we = 1 for sw only.
  - Wait indefinitely for dmem_ready.
  - On ready, sw: pc_write = 1, pc_src = 0, retired++, next FETCH.
  - On ready, lw: next WB.
- WB (1 cycle):
  - reg_write = 1; mem_to_reg = 1 for lw, 0 otherwise.
  - alu_op and alu_src_b held at EXEC values.
  - pc_write = 1, pc_src = 0, retired++, next FETCH.
- Defaults: alu_op = 00 and alu_src_b = 0 outside EXEC/MEM/WB.
- funct3/funct7 are driven from IR at all times.
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.
- Latency with zero-wait memories:
  - R-type and lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- The register file handles rd = x0 suppression; this block still pulses reg_write.
- retired wraps from all-ones to 0 without a flag.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB)
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_LUI)
  - ALUOp constants (ALUOP_ADD = 00, ALUOP_BR = 01, ALUOP_R = 10, ALUOP_LUI = 11)
  - instruction-class enum
- One combinational sub-module, instr_class_dec: opcode in, class enum and illegal out. Shared with future hazard logic.

Test Plan:
- Zero-wait memories, instr = 0x002081B3 (add x3,x1,x2):
  - ir_write at cycle 1; alu_op = 10, funct3 = 000, funct7 = 0000000 in EXEC.
  - reg_write = 1, mem_to_reg = 0 in WB with pc_write = 1, pc_src = 0; retired 0 -> 1.
- lw 0x0000A183 with dmem_ready delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we = 0, alu_op = 00 and alu_src_b = 1 throughout.
  - Then WB with mem_to_reg = 1, reg_write = 1.
- beq 0x00208463:
  - zero = 1: pc_write = 1, pc_src = 1 in EXEC.
  - zero = 0: pc_src = 0.
  - No reg_write either way; retired increments.
- sw 0x0020A023 then lui 0x123450B7:
  - sw: dmem_we = 1, no reg_write.
  - lui: alu_op = 11, alu_src_b = 1, reg_write in WB.
- instr = 0xFFFFFFFF: illegal pulses exactly 1 cycle in DECODE; pc_write = 1; retired unchanged; next cycle imem_req = 1.
- Robustness:
  - rst asserted during a MEM wait: all outputs 0 immediately, no pc_write; after release, state FETCH and imem_req = 1.
  - Preload retired to all-ones via 2^CNT_W-1 instructions (CNT_W = 4 build): the next retire wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle main control unit.
// Imported by the FSM and by the instruction class decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    typedef enum logic [2:0] {
        CL_R,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_LUI,
        CL_ILL
    } iclass_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

    // ALU setup chosen in EXEC and held through MEM/WB.
    function automatic logic [1:0] exec_aluop(iclass_e c);
        logic [1:0] op;
        op = ALUOP_ADD;
        case (c)
            CL_R:    op = ALUOP_R;
            CL_BEQ:  op = ALUOP_BR;
            CL_LUI:  op = ALUOP_LUI;
            default: op = ALUOP_ADD;
        endcase
        return op;
    endfunction

    function automatic logic exec_srcb(iclass_e c);
        return (c == CL_LW) || (c == CL_SW) || (c == CL_LUI);
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Opcode classifier; kept standalone so hazard logic can reuse it.
import ctrl_pkg::*;

module instr_class_dec (
    input  logic [6:0] opcode,
    output iclass_e    iclass,
    output logic       illegal
);

    always_comb begin
        iclass = CL_ILL;
        unique case (opcode)
            OP_R:    iclass = CL_R;
            OP_LW:   iclass = CL_LW;
            OP_SW:   iclass = CL_SW;
            OP_BEQ:  iclass = CL_BEQ;
            OP_LUI:  iclass = CL_LUI;
            default: iclass = CL_ILL;
        endcase
        illegal = (iclass == CL_ILL);
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 subset core.
// Holds the IR, drives datapath strobes and counts retired instructions.
import ctrl_pkg::*;

module main_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      instr,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             zero,
    output logic             ir_write,
    output logic [1:0]       alu_op,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic             alu_src_b,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    iclass_e          cls;
    logic             cls_ill;

    instr_class_dec u_dec (
        .opcode  (ir_q[6:0]),
        .iclass  (cls),
        .illegal (cls_ill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_op     = ALUOP_ADD;
        alu_src_b  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        // Strobes are forced low while reset is held so an abandoned
        // access can never commit a PC or register write.
        if (!rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        ir_d     = instr;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    if (cls_ill) begin
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d  = EXEC;
                    end
                end
                EXEC: begin
                    alu_op    = exec_aluop(cls);
                    alu_src_b = exec_srcb(cls);
                    unique case (cls)
                        CL_R, CL_LUI: state_d = WB;
                        CL_LW, CL_SW: state_d = MEM;
                        CL_BEQ: begin
                            pc_write  = 1'b1;
                            pc_src    = zero;
                            retired_d = retired_q + 1'b1;
                            state_d   = FETCH;
                        end
                        default: state_d = FETCH;
                    endcase
                end
                MEM: begin
                    alu_op    = ALUOP_ADD;
                    alu_src_b = 1'b1;
                    dmem_req  = 1'b1;
                    dmem_we   = (cls == CL_SW);
                    if (dmem_ready) begin
                        if (cls == CL_SW) begin
                            pc_write  = 1'b1;
                            retired_d = retired_q + 1'b1;
                            state_d   = FETCH;
                        end else begin
                            state_d   = WB;
                        end
                    end
                end
                WB: begin
                    alu_op     = exec_aluop(cls);
                    alu_src_b  = exec_srcb(cls);
                    reg_write  = 1'b1;
                    mem_to_reg = (cls == CL_LW);
                    pc_write   = 1'b1;
                    retired_d  = retired_q + 1'b1;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign retired = retired_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Randomised scoreboard bench for main_ctrl_fsm (CNT_W = 4 build).
// Memory responders issue instructions; a monitor checks each retirement.
module tb_main_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req, imem_ready;
    logic [31:0]   instr;
    logic          dmem_req, dmem_we, dmem_ready, zero;
    logic          ir_write;
    logic [1:0]    alu_op;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          alu_src_b, pc_write, pc_src;
    logic          reg_write, mem_to_reg, illegal;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    main_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .instr      (instr),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .zero       (zero),
        .ir_write   (ir_write),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_src_b  (alu_src_b),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .retired    (retired)
    );

    // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 lui, 5 illegal
    typedef struct {
        logic [31:0] instr;
        int          iw;
        int          dw;
        logic        z;
        int          kind;
    } item_t;

    typedef struct {
        int cycles; int dreq; int we;  int regw; int m2r;
        int ill;    int psrc; int aop; int asrc; int hold;
        int f3;     int f7;   int ret;
    } rec_t;

    int    n_cmp  = 0;
    int    n_fail = 0;
    rec_t  exp_q[$];
    item_t dir_q[$];

    item_t cur, forced;
    int    model_ret = 0;
    int    issued = 0;
    int    ncyc = 0;
    int    icnt = 0;
    int    dcnt = 0;
    bit    fetching = 0;
    bit    in_mem = 0;
    bit    stop_gen = 0;
    bit    push_en = 1;
    bit    force_next = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 ||
               op == 7'b1100011 || op == 7'b0110111;
    endfunction

    function automatic item_t gen_item();
        item_t       it;
        logic [31:0] r;
        logic [6:0]  op;
        int          k;
        k  = $urandom_range(0, 5);
        r  = $urandom();
        op = 7'b0110011;
        case (k)
            1: op = 7'b0000011;
            2: op = 7'b0100011;
            3: op = 7'b1100011;
            4: op = 7'b0110111;
            5: begin
                op = r[6:0];
                while (is_legal(op)) op = 7'($urandom());
                if ($urandom_range(0, 3) == 0) begin
                    r  = '1;
                    op = 7'h7f;
                end
            end
            default: op = 7'b0110011;
        endcase
        it.instr = {r[31:7], op};
        it.kind  = k;
        it.iw    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        it.dw    = $urandom_range(0, 3);
        it.z     = 1'($urandom_range(0, 1));
        return it;
    endfunction

    // Expected observable behaviour of one instruction, from the ISA rules.
    function automatic rec_t model(input item_t it, input int ret);
        rec_t e = '{default: 0};
        e.hold = 1;
        e.f3   = int'(it.instr[14:12]);
        e.f7   = int'(it.instr[31:25]);
        e.ret  = ret % (1 << CW);
        case (it.kind)
            0: begin e.cycles = 4; e.aop = 2; e.regw = 1; end
            1: begin
                e.cycles = 5 + it.dw; e.asrc = 1; e.regw = 1;
                e.m2r = 1; e.dreq = it.dw + 1;
            end
            2: begin
                e.cycles = 4 + it.dw; e.asrc = 1;
                e.dreq = it.dw + 1; e.we = 1;
            end
            3: begin e.cycles = 3; e.aop = 1; e.psrc = int'(it.z); end
            4: begin e.cycles = 4; e.aop = 3; e.asrc = 1; e.regw = 1; end
            default: begin e.cycles = 2; e.ill = 1; end
        endcase
        return e;
    endfunction

    task automatic drive();
        ncyc++;
        if (imem_req) begin
            if (!fetching && !stop_gen) begin
                fetching = 1;
                if (force_next) cur = forced;
                else if (dir_q.size() > 0) cur = dir_q.pop_front();
                else cur = gen_item();
                force_next = 0;
                icnt = cur.iw;
                zero = cur.z;
                issued++;
                if (push_en) begin
                    exp_q.push_back(model(cur, model_ret));
                    if (cur.kind != 5) model_ret++;
                end
            end
            if (!fetching) begin
                imem_ready = 1'b0;
            end else if (icnt == 0) begin
                imem_ready = 1'b1;
                instr      = cur.instr;
                fetching   = 0;
            end else begin
                imem_ready = 1'b0;
                instr      = $urandom();
                icnt--;
            end
        end else begin
            imem_ready = 1'($urandom_range(0, 1));
            instr      = $urandom();
        end
        if (dmem_req) begin
            if (!in_mem) begin
                in_mem = 1;
                dcnt   = cur.dw;
            end
            if (dcnt == 0) begin
                dmem_ready = 1'b1;
                in_mem     = 0;
            end else begin
                dmem_ready = 1'b0;
                dcnt--;
            end
        end else begin
            dmem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
    endtask

    task automatic drain();
        int g = 0;
        stop_gen = 1;
        while (exp_q.size() > 0 && g < 400) begin
            cycle();
            g++;
        end
        chk("drain_done", exp_q.size(), 0);
        cycle();
        cycle();
    endtask

    // Monitor: builds one record per instruction, from ir_write to pc_write.
    rec_t a;
    int   idx = 0;
    bit   busy = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                busy = 0;
            end else begin
                if (ir_write && !busy) begin
                    busy   = 1;
                    idx    = 0;
                    a      = '{default: 0};
                    a.hold = 1;
                    a.ret  = int'(retired);
                end
                if (busy) begin
                    if (idx > 0) begin
                        chk("ir_write_outside_fetch", int'(ir_write), 0);
                        chk("imem_req_outside_fetch", int'(imem_req), 0);
                    end
                    if (idx < 2 && (alu_op != 2'b00 || alu_src_b)) a.hold = 0;
                    if (idx == 1) begin
                        a.f3 = int'(funct3);
                        a.f7 = int'(funct7);
                    end
                    if (idx == 2) begin
                        a.aop  = int'(alu_op);
                        a.asrc = int'(alu_src_b);
                    end
                    if (idx > 2 && (int'(alu_op) != a.aop || int'(alu_src_b) != a.asrc))
                        a.hold = 0;
                    a.dreq += int'(dmem_req);
                    if (dmem_req && dmem_we) a.we = 1;
                    a.regw += int'(reg_write);
                    if (reg_write) a.m2r = int'(mem_to_reg);
                    a.ill += int'(illegal);
                    if (pc_write) begin
                        rec_t e;
                        a.psrc   = int'(pc_src);
                        a.cycles = idx + 1;
                        busy     = 0;
                        chk("expected_pending", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("latency", a.cycles, e.cycles);
                            chk("dmem_req_cycles", a.dreq, e.dreq);
                            chk("dmem_we", a.we, e.we);
                            chk("reg_write_cnt", a.regw, e.regw);
                            chk("mem_to_reg", a.m2r, e.m2r);
                            chk("illegal_cnt", a.ill, e.ill);
                            chk("pc_src", a.psrc, e.psrc);
                            chk("alu_op", a.aop, e.aop);
                            chk("alu_src_b", a.asrc, e.asrc);
                            chk("alu_hold", a.hold, e.hold);
                            chk("funct3", a.f3, e.f3);
                            chk("funct7", a.f7, e.f7);
                            chk("retired_before", a.ret, e.ret);
                        end
                    end
                    idx++;
                end else begin
                    chk("idle_imem_req", int'(imem_req), 1);
                    chk("idle_strobes", int'({pc_write, reg_write, dmem_req, illegal}), 0);
                end
            end
        end
    end

    initial begin
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        instr      = '0;
        zero       = 1'b0;
        dir_q.push_back('{instr: 32'h002081B3, iw: 0, dw: 0, z: 1'b0, kind: 0});
        dir_q.push_back('{instr: 32'h0000A183, iw: 1, dw: 3, z: 1'b0, kind: 1});
        dir_q.push_back('{instr: 32'h00208463, iw: 0, dw: 0, z: 1'b1, kind: 3});
        dir_q.push_back('{instr: 32'h00208463, iw: 0, dw: 0, z: 1'b0, kind: 3});
        dir_q.push_back('{instr: 32'h0020A023, iw: 0, dw: 2, z: 1'b0, kind: 2});
        dir_q.push_back('{instr: 32'h123450B7, iw: 0, dw: 0, z: 1'b0, kind: 4});
        dir_q.push_back('{instr: 32'hFFFFFFFF, iw: 0, dw: 0, z: 1'b0, kind: 5});

        repeat (2) @(negedge clk);
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_funct3", int'(funct3), 0);
        chk("rst_funct7", int'(funct7), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_strobes", int'({pc_write, reg_write, ir_write, dmem_req}), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", int'(imem_req), 1);
        drive();

        while (issued < 60 && ncyc < 5000) cycle();
        drain();

        // Reset during a long data-memory wait; the lw must never commit.
        stop_gen   = 0;
        push_en    = 0;
        forced     = '{instr: 32'h0000A183, iw: 0, dw: 50, z: 1'b0, kind: 1};
        force_next = 1;
        begin
            int g = 0;
            while (!dmem_req && g < 20) begin
                cycle();
                g++;
            end
        end
        chk("reach_mem_wait", int'(dmem_req), 1);
        cycle();
        cycle();
        #3;
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("rst_mem_strobes",
            int'({pc_write, reg_write, dmem_req, dmem_we, imem_req}), 0);
        chk("rst_mem_alu", int'({alu_op, alu_src_b}), 0);
        chk("rst_mem_retired", int'(retired), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_pc_write", int'(pc_write), 0);
        end
        fetching  = 0;
        in_mem    = 0;
        model_ret = 0;
        push_en   = 1;
        issued    = 0;
        rst       = 1'b0;
        #1;
        chk("rst_release_imem_req", int'(imem_req), 1);
        drive();

        while (issued < 40 && ncyc < 9000) cycle();
        drain();
        chk("final_retired", int'(retired), model_ret % (1 << CW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
